// File: rtl/ram_mp_pkg.sv
// Shared types and helpers for the multi-port synchronous RAM:
// sweep states, write-mask expansion/merge and address range check.
package ram_mp_pkg;

  localparam int MAX_W = 64;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } sweep_state_e;

  function automatic int mask_width(input int data_w, input int mask_g);
    return data_w / mask_g;
  endfunction

  function automatic logic addr_in_range(input logic [MAX_W-1:0] addr,
                                         input longint unsigned depth);
    return addr < depth;
  endfunction

  // Each mask bit enables mask_g consecutive data bits.
  function automatic logic [MAX_W-1:0] mask_expand(input logic [MAX_W-1:0] mask,
                                                   input int mask_g);
    logic [MAX_W-1:0] bits;
    logic [5:0]       lane;
    logic [5:0]       idx;
    bits = '0;
    for (int b = 0; b < MAX_W; b++) begin
      idx       = 6'(b);
      lane      = 6'(b / mask_g);
      bits[idx] = mask[lane];
    end
    return bits;
  endfunction

  function automatic logic [MAX_W-1:0] merge_word(input logic [MAX_W-1:0] old_w,
                                                  input logic [MAX_W-1:0] new_w,
                                                  input logic [MAX_W-1:0] mask,
                                                  input int mask_g);
    logic [MAX_W-1:0] m;
    m = mask_expand(mask, mask_g);
    return (old_w & ~m) | (new_w & m);
  endfunction

endpackage

// File: rtl/ram_rd_pipe.sv
// Per-port read pipeline: RD_LAT stages of valid/data; the last stage
// only loads on a valid beat so the output holds its last delivered word.
module ram_rd_pipe #(
  parameter int DATA_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o
);

  logic              vld_q [RD_LAT];
  logic [DATA_W-1:0] dat_q [RD_LAT];

  // Shift stages; each stage keeps its word unless a valid beat arrives.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < RD_LAT; s++) begin
        vld_q[s] <= 1'b0;
        dat_q[s] <= '0;
      end
    end else begin
      vld_q[0] <= valid_i;
      if (valid_i) begin
        dat_q[0] <= data_i;
      end
      for (int s = 1; s < RD_LAT; s++) begin
        vld_q[s] <= vld_q[s-1];
        if (vld_q[s-1]) begin
          dat_q[s] <= dat_q[s-1];
        end
      end
    end
  end

  assign valid_o = vld_q[RD_LAT-1];
  assign data_o  = dat_q[RD_LAT-1];

endmodule

// File: rtl/ram_mp_sync.sv
// Multi-read-port synchronous RAM with one masked write port, configurable
// read latency, collision policy and an optional zero-fill sweep after reset.
module ram_mp_sync
  import ram_mp_pkg::*;
#(
  parameter int DATA_W         = 16,
  parameter int ADDR_W         = 16,
  parameter int DEPTH          = 65536,
  parameter int NUM_RD         = 2,
  parameter int RD_LAT         = 1,
  parameter int MASK_G         = 8,
  parameter int WRITE_FIRST    = 1,
  parameter int CLEAR_ON_RESET = 1,
  localparam int MASK_W        = mask_width(DATA_W, MASK_G)
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     busy,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_valid,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [MASK_W-1:0]        wr_mask
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  sweep_state_e      state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              wr_ok;
  logic [DATA_W-1:0] wr_merged;
  logic              mem_we_d;
  logic [IDX_W-1:0]  mem_waddr_d;
  logic [DATA_W-1:0] mem_wdata_d;
  logic [ADDR_W-1:0] rd_sel;
  logic [NUM_RD-1:0] rd_go;
  logic [DATA_W-1:0] rd_word [NUM_RD];

  assign busy = (state_q == CLEAR);

  // Sweep state and address counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Sweep next state: leave CLEAR once the last word has been zeroed.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      CLEAR: begin
        if (cnt_q == LAST_ADDR) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      IDLE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign wr_ok = wr_en && !busy && !reset &&
                 addr_in_range(MAX_W'(wr_addr), 64'(DEPTH));
  assign wr_merged = DATA_W'(merge_word(MAX_W'(mem_q[wr_addr[IDX_W-1:0]]),
                                        MAX_W'(wr_data), MAX_W'(wr_mask), MASK_G));

  // Single memory write port shared by the sweep and user writes.
  always_comb begin
    mem_we_d    = 1'b0;
    mem_waddr_d = '0;
    mem_wdata_d = '0;
    if (busy && !reset) begin
      mem_we_d    = 1'b1;
      mem_waddr_d = cnt_q[IDX_W-1:0];
    end else if (wr_ok) begin
      mem_we_d    = 1'b1;
      mem_waddr_d = wr_addr[IDX_W-1:0];
      mem_wdata_d = wr_merged;
    end else begin
      mem_we_d    = 1'b0;
    end
  end

  // Storage is deliberately left untouched by reset.
  always_ff @(posedge clk) begin
    if (mem_we_d) begin
      mem_q[mem_waddr_d] <= mem_wdata_d;
    end
  end

  // Per-port read word, including same-edge write bypass when write-first.
  always_comb begin
    rd_sel = '0;
    rd_go  = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      rd_sel   = rd_addr[i*ADDR_W +: ADDR_W];
      rd_go[i] = rd_en[i] && !busy;
      if (!addr_in_range(MAX_W'(rd_sel), 64'(DEPTH))) begin
        rd_word[i] = '0;
      end else if ((WRITE_FIRST != 0) && wr_ok && (rd_sel == wr_addr)) begin
        rd_word[i] = wr_merged;
      end else begin
        rd_word[i] = mem_q[rd_sel[IDX_W-1:0]];
      end
    end
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    ram_rd_pipe #(
      .DATA_W(DATA_W),
      .RD_LAT(RD_LAT)
    ) u_pipe (
      .clk    (clk),
      .reset  (reset),
      .valid_i(rd_go[g]),
      .data_i (rd_word[g]),
      .valid_o(rd_valid[g]),
      .data_o (rd_data[g*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_ram_mp_sync.sv
// Directed bench: a write-first 2-port RD_LAT=3 instance and a read-first
// 1-port RD_LAT=1 instance, both DEPTH=16 with the clear sweep enabled.
module tb_ram_mp_sync;

  logic        clk;
  logic        rst;
  logic        busy;
  logic [1:0]  rd_en;
  logic [31:0] rd_addr;
  logic [31:0] rd_data;
  logic [1:0]  rd_valid;
  logic        wr_en;
  logic [15:0] wr_addr;
  logic [15:0] wr_data;
  logic [1:0]  wr_mask;

  logic        b_busy;
  logic [0:0]  b_rd_en;
  logic [15:0] b_rd_addr;
  logic [15:0] b_rd_data;
  logic [0:0]  b_rd_valid;
  logic        b_wr_en;
  logic [15:0] b_wr_addr;
  logic [15:0] b_wr_data;
  logic [1:0]  b_wr_mask;

  int errors = 0;
  int checks = 0;

  ram_mp_sync #(.DATA_W(16), .ADDR_W(16), .DEPTH(16), .NUM_RD(2), .RD_LAT(3),
                .MASK_G(8), .WRITE_FIRST(1), .CLEAR_ON_RESET(1)) dut (
    .clk(clk), .reset(rst), .busy(busy), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_valid(rd_valid), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_mask(wr_mask));

  ram_mp_sync #(.DATA_W(16), .ADDR_W(16), .DEPTH(16), .NUM_RD(1), .RD_LAT(1),
                .MASK_G(8), .WRITE_FIRST(0), .CLEAR_ON_RESET(1)) dut_rf (
    .clk(clk), .reset(rst), .busy(b_busy), .rd_en(b_rd_en), .rd_addr(b_rd_addr),
    .rd_data(b_rd_data), .rd_valid(b_rd_valid), .wr_en(b_wr_en), .wr_addr(b_wr_addr),
    .wr_data(b_wr_data), .wr_mask(b_wr_mask));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_a(input logic [15:0] a, input logic [15:0] d, input logic [1:0] m);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_mask = m;
    tick();
    wr_en = 1'b0; wr_mask = 2'b00;
  endtask

  task automatic wr_b(input logic [15:0] a, input logic [15:0] d, input logic [1:0] m);
    b_wr_en = 1'b1; b_wr_addr = a; b_wr_data = d; b_wr_mask = m;
    tick();
    b_wr_en = 1'b0; b_wr_mask = 2'b00;
  endtask

  task automatic rd_a(input int p, input logic [15:0] a, output logic [15:0] d, output int lat);
    rd_en = 2'b00;
    rd_en[p] = 1'b1;
    rd_addr[p*16 +: 16] = a;
    tick();
    rd_en = 2'b00;
    lat = 1;
    while (!rd_valid[p] && lat < 10) begin
      tick();
      lat++;
    end
    d = rd_data[p*16 +: 16];
  endtask

  task automatic rd_b(input logic [15:0] a, output logic [15:0] d, output int lat);
    b_rd_en = 1'b1; b_rd_addr = a;
    tick();
    b_rd_en = 1'b0;
    lat = 1;
    while (!b_rd_valid[0] && lat < 10) begin
      tick();
      lat++;
    end
    d = b_rd_data;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    int n;
    logic seen;
    rst = 1'b1;
    tick(); tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b want 1", busy); end
    checks++; if (rd_valid !== 2'b00) begin errors++; $display("FAIL reset_valid: got %b want 00", rd_valid); end
    checks++; if (rd_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 0", rd_data); end
    checks++; if (b_busy !== 1'b1) begin errors++; $display("FAIL reset_busy_rf: got %b want 1", b_busy); end
    checks++; if (b_rd_data !== 16'h0) begin errors++; $display("FAIL reset_data_rf: got %h want 0", b_rd_data); end
    rst = 1'b0;
    rd_en = 2'b11; rd_addr = 32'h0; b_rd_en = 1'b1; b_rd_addr = 16'h0;
    n = 0; seen = 1'b0;
    while (busy && n < 100) begin
      tick();
      n++;
      if (rd_valid != 2'b00 || b_rd_valid != 1'b0) seen = 1'b1;
    end
    rd_en = 2'b00; b_rd_en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (rd_valid != 2'b00 || b_rd_valid != 1'b0) seen = 1'b1;
    end
    checks++; if (n !== 16) begin errors++; $display("FAIL sweep_len: got %0d want 16", n); end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL busy_drop: got %b want 0", seen); end
    checks++; if (b_busy !== 1'b0) begin errors++; $display("FAIL sweep_end_rf: got %b want 0", b_busy); end
  endtask

  task automatic test_sweep_clear();
    logic [15:0] d;
    int lat, n;
    for (int a = 0; a < 16; a++) wr_a(16'(a), 16'hFFFF, 2'b11);
    rd_a(0, 16'd9, d, lat);
    checks++; if (d !== 16'hFFFF) begin errors++; $display("FAIL preload: got %h want ffff", d); end
    rst = 1'b1; tick(); rst = 1'b0;
    wait_idle(n);
    for (int a = 0; a < 16; a++) begin
      rd_a(a % 2, 16'(a), d, lat);
      checks++; if (d !== 16'h0000) begin errors++; $display("FAIL sweep_zero[%0d]: got %h want 0000", a, d); end
    end
  endtask

  task automatic test_masked_write();
    logic [15:0] d;
    int lat;
    wr_a(16'd5, 16'h1234, 2'b11);
    wr_a(16'd5, 16'hAB00, 2'b10);
    rd_a(0, 16'd5, d, lat);
    checks++; if (d !== 16'hAB34) begin errors++; $display("FAIL mask_merge: got %h want ab34", d); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL read_latency: got %0d want 3", lat); end
    wr_a(16'd5, 16'hFFFF, 2'b00);
    rd_a(1, 16'd5, d, lat);
    checks++; if (d !== 16'hAB34) begin errors++; $display("FAIL mask_zero: got %h want ab34", d); end
  endtask

  task automatic test_collision();
    logic [15:0] d;
    int lat;
    wr_a(16'd3, 16'h00FF, 2'b11);
    wr_en = 1'b1; wr_addr = 16'd3; wr_data = 16'hAA55; wr_mask = 2'b11;
    rd_en = 2'b11; rd_addr = {16'd3, 16'd3};
    tick();
    wr_en = 1'b0; rd_en = 2'b00;
    lat = 1;
    while (!rd_valid[0] && lat < 10) begin tick(); lat++; end
    checks++; if (rd_data[15:0] !== 16'hAA55) begin errors++; $display("FAIL coll_wf_p0: got %h want aa55", rd_data[15:0]); end
    checks++; if (rd_data[31:16] !== 16'hAA55 || rd_valid !== 2'b11) begin errors++; $display("FAIL coll_wf_p1: got %h/%b want aa55/11", rd_data[31:16], rd_valid); end
    rd_a(0, 16'd3, d, lat);
    checks++; if (d !== 16'hAA55) begin errors++; $display("FAIL coll_after: got %h want aa55", d); end
    wr_en = 1'b1; wr_addr = 16'd3; wr_data = 16'h1166; wr_mask = 2'b01;
    rd_en = 2'b01; rd_addr[15:0] = 16'd3;
    tick();
    wr_en = 1'b0; rd_en = 2'b00;
    lat = 1;
    while (!rd_valid[0] && lat < 10) begin tick(); lat++; end
    checks++; if (rd_data[15:0] !== 16'hAA66) begin errors++; $display("FAIL coll_partial: got %h want aa66", rd_data[15:0]); end
  endtask

  task automatic test_collision_rf();
    logic [15:0] d;
    int lat;
    wr_b(16'd3, 16'h00FF, 2'b11);
    b_wr_en = 1'b1; b_wr_addr = 16'd3; b_wr_data = 16'hAA55; b_wr_mask = 2'b11;
    b_rd_en = 1'b1; b_rd_addr = 16'd3;
    tick();
    b_wr_en = 1'b0; b_rd_en = 1'b0;
    checks++; if (b_rd_valid !== 1'b1 || b_rd_data !== 16'h00FF) begin errors++; $display("FAIL coll_rf: got %b/%h want 1/00ff", b_rd_valid, b_rd_data); end
    rd_b(16'd3, d, lat);
    checks++; if (d !== 16'hAA55) begin errors++; $display("FAIL coll_rf_after: got %h want aa55", d); end
    checks++; if (lat !== 1) begin errors++; $display("FAIL latency_rf: got %0d want 1", lat); end
  endtask

  task automatic test_back_to_back();
    int cnt0, cnt1, first0, first1, last0, last1;
    logic [15:0] exp;
    for (int k = 0; k < 8; k++) wr_a(16'(k), 16'hC000 + 16'(k), 2'b11);
    cnt0 = 0; cnt1 = 0; first0 = -1; first1 = -1; last0 = -1; last1 = -1;
    for (int c = 0; c < 16; c++) begin
      if (c < 8) begin
        rd_en = 2'b11;
        rd_addr = {16'(7 - c), 16'(c)};
      end else begin
        rd_en = 2'b00;
      end
      tick();
      if (rd_valid[0]) begin
        exp = 16'hC000 + 16'(cnt0);
        checks++; if (rd_data[15:0] !== exp) begin errors++; $display("FAIL stream_p0[%0d]: got %h want %h", cnt0, rd_data[15:0], exp); end
        if (first0 < 0) first0 = c;
        last0 = c; cnt0++;
      end
      if (rd_valid[1]) begin
        exp = 16'hC000 + 16'(7 - cnt1);
        checks++; if (rd_data[31:16] !== exp) begin errors++; $display("FAIL stream_p1[%0d]: got %h want %h", cnt1, rd_data[31:16], exp); end
        if (first1 < 0) first1 = c;
        last1 = c; cnt1++;
      end
    end
    checks++; if (cnt0 !== 8 || cnt1 !== 8) begin errors++; $display("FAIL stream_count: got %0d/%0d want 8/8", cnt0, cnt1); end
    checks++; if (first0 !== 2 || last0 !== 9 || first1 !== 2 || last1 !== 9) begin errors++; $display("FAIL stream_window: got %0d..%0d/%0d..%0d want 2..9", first0, last0, first1, last1); end
  endtask

  task automatic test_out_of_range();
    logic [15:0] d;
    int lat;
    wr_a(16'd4, 16'h4444, 2'b11);
    wr_a(16'd20, 16'h5555, 2'b11);
    rd_a(0, 16'd20, d, lat);
    checks++; if (d !== 16'h0000 || lat !== 3) begin errors++; $display("FAIL oor_read: got %h lat %0d want 0000 lat 3", d, lat); end
    rd_a(1, 16'd4, d, lat);
    checks++; if (d !== 16'h4444) begin errors++; $display("FAIL oor_write: got %h want 4444", d); end
  endtask

  task automatic test_reset_mid_sweep();
    int n;
    rst = 1'b1; tick(); rst = 1'b0;
    for (int k = 0; k < 7; k++) tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_sweep_busy: got %b want 1", busy); end
    rst = 1'b1; tick(); rst = 1'b0;
    wait_idle(n);
    checks++; if (n !== 16) begin errors++; $display("FAIL restart_len: got %0d want 16", n); end
  endtask

  task automatic test_reset_inflight();
    logic [15:0] d;
    int lat, n;
    logic seen;
    wr_a(16'd2, 16'h2222, 2'b11);
    rd_a(0, 16'd2, d, lat);
    checks++; if (d !== 16'h2222) begin errors++; $display("FAIL inflight_pre: got %h want 2222", d); end
    rd_en = 2'b01; rd_addr[15:0] = 16'd2;
    tick(); tick();
    rd_en = 2'b00;
    rst = 1'b1;
    tick();
    checks++; if (rd_valid !== 2'b00 || rd_data !== 32'h0) begin errors++; $display("FAIL inflight_reset: got %b/%h want 00/0", rd_valid, rd_data); end
    rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (rd_valid != 2'b00) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0 || rd_data !== 32'h0) begin errors++; $display("FAIL inflight_after: got %b/%h want 0/0", seen, rd_data); end
    wait_idle(n);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL final_idle: got %b want 0", busy); end
  endtask

  initial begin
    rst = 1'b1;
    rd_en = 2'b00; rd_addr = 32'h0; wr_en = 1'b0; wr_addr = 16'h0; wr_data = 16'h0; wr_mask = 2'b00;
    b_rd_en = 1'b0; b_rd_addr = 16'h0; b_wr_en = 1'b0; b_wr_addr = 16'h0; b_wr_data = 16'h0; b_wr_mask = 2'b00;
    test_reset();
    test_sweep_clear();
    test_masked_write();
    test_collision();
    test_collision_rf();
    test_back_to_back();
    test_out_of_range();
    test_reset_mid_sweep();
    test_reset_inflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
